fetch_predictor: RTL

IF-stage fetch-PC and branch-prediction unit. It is the producer side of the ID-stage branch check. It owns the PC register and looks up a table of 2-bit saturating counters for each conditional branch fetched. It predicts and redirects fetch in IF, records the prediction for the ID stage, then consumes the ID resolution: it trains the counters and raises `IF_Flush` with a corrected PC on a mispredict or an unconditional jump.

---
 rtl/fetch_predictor_if.sv | 26 ++
 rtl/fetch_predictor.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fetch_predictor_if.sv
// Fetch/ID signal bundle for the IF-stage predictor.
// The slave modport is the predictor side; the master modport drives fetch and ID results.
interface fetch_predictor_if;
  logic [5:0]  IF_op;
  logic [15:0] IF_imm;
  logic        ID_stall;
  logic        ID_taken;
  logic        ID_jump;
  logic [31:0] ID_jump_target;
  logic [31:0] pc;
  logic        IF_predict;
  logic        IF_Flush;
  logic        mispredict;
  logic [15:0] br_count;
  logic [15:0] miss_count;

  modport master (
    output IF_op, IF_imm, ID_stall, ID_taken, ID_jump, ID_jump_target,
    input  pc, IF_predict, IF_Flush, mispredict, br_count, miss_count
  );

  modport slave (
    input  IF_op, IF_imm, ID_stall, ID_taken, ID_jump, ID_jump_target,
    output pc, IF_predict, IF_Flush, mispredict, br_count, miss_count
  );
endinterface

// File: rtl/fetch_predictor.sv
// IF-stage PC register with a 2-bit saturating-counter branch predictor.
// Predicts in IF, records the prediction for ID, then trains and redirects on resolution.
module fetch_predictor #(
  parameter int unsigned IDX_BITS = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clock,
  input logic               reset,
  fetch_predictor_if.slave  bus
);
  localparam int unsigned Entries = 2 ** IDX_BITS;

  logic [31:0]         r_pc;
  logic [1:0]          r_ctr [Entries];
  logic                r_v;
  logic                r_pred;
  logic [IDX_BITS-1:0] r_idx;
  logic [31:0]         r_fall;
  logic [31:0]         r_tgt;
  logic [15:0]         r_br_count;
  logic [15:0]         r_miss_count;

  logic                w_detect;
  logic [IDX_BITS-1:0] w_idx;
  logic [1:0]          w_ctr_cur;
  logic                w_predict;
  logic [31:0]         w_offset;
  logic [31:0]         w_fall;
  logic [31:0]         w_pred_target;
  logic                w_resolve;
  logic                w_miss;
  logic                w_flush;
  logic [31:0]         w_redirect;
  logic [31:0]         w_pc_next;
  logic [1:0]          w_ctr_old;
  logic [1:0]          w_ctr_new;

  always_comb begin
    w_detect = 1'b0;
    unique case (bus.IF_op)
      6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001: w_detect = 1'b1;
      default: w_detect = 1'b0;
    endcase
  end

  assign w_idx         = r_pc[IDX_BITS+1:2];
  assign w_ctr_cur     = r_ctr[w_idx];
  assign w_predict     = w_detect & w_ctr_cur[1];
  assign w_offset      = {{14{bus.IF_imm[15]}}, bus.IF_imm, 2'b00};
  assign w_fall        = r_pc + 32'd4;
  assign w_pred_target = w_fall + w_offset;

  assign w_resolve  = r_v & ~bus.ID_stall;
  assign w_miss     = w_resolve & (r_pred ^ bus.ID_taken);
  assign w_flush    = w_miss | (bus.ID_jump & ~bus.ID_stall);
  // A branch mispredict outranks a simultaneous jump.
  assign w_redirect = w_miss ? (bus.ID_taken ? r_tgt : r_fall) : bus.ID_jump_target;

  always_comb begin
    w_pc_next = w_fall;
    if (w_flush) begin
      w_pc_next = w_redirect;
    end else if (bus.ID_stall) begin
      w_pc_next = r_pc;
    end else if (w_predict) begin
      w_pc_next = w_pred_target;
    end
  end

  assign w_ctr_old = r_ctr[r_idx];
  always_comb begin
    w_ctr_new = w_ctr_old;
    if (bus.ID_taken) begin
      if (w_ctr_old != 2'b11) w_ctr_new = w_ctr_old + 2'd1;
    end else begin
      if (w_ctr_old != 2'b00) w_ctr_new = w_ctr_old - 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc   <= RESET_PC;
      r_v    <= 1'b0;
      r_pred <= 1'b0;
      r_idx  <= '0;
      r_fall <= '0;
      r_tgt  <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (!bus.ID_stall) begin
        r_v    <= w_detect & ~w_flush;
        r_pred <= w_predict;
        r_idx  <= w_idx;
        r_fall <= w_fall;
        r_tgt  <= w_pred_target;
      end
    end
  end

  // Lookups this cycle see the pre-update value; no bypass.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Entries; i++) r_ctr[i] <= 2'b10;
    end else if (w_resolve) begin
      r_ctr[r_idx] <= w_ctr_new;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_br_count   <= '0;
      r_miss_count <= '0;
    end else if (w_resolve) begin
      if (r_br_count != 16'hFFFF) r_br_count <= r_br_count + 16'd1;
      if (w_miss && r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
    end
  end

  assign bus.pc         = r_pc;
  assign bus.IF_predict = w_predict;
  assign bus.IF_Flush   = w_flush;
  assign bus.mispredict = w_miss;
  assign bus.br_count   = r_br_count;
  assign bus.miss_count = r_miss_count;
endmodule
